tppe_spike_event_scanner: RTL and testbench
===========================================

Name: tppe_spike_event_scanner

Overview:
Sits directly downstream of the temporal spike compressor. Takes a captured T_WINDOW-bit spike pattern plus the synaptic weight of that input. Converts the dense bit pattern into a sparse stream of (timestep, weight) events, one per set bit, oldest spike first. The stream feeds the LIF accumulation stage, and zero bits cost no cycles.

Parameters:
T_WINDOW, 16, pattern width in timesteps; must be >= 2.
W_WIDTH, 8, synaptic weight width, signed two's complement, passed through unmodified.
TW, $clog2(T_WINDOW), localparam, timestep index width.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  pattern_in/weight_in valid.
in_ready  output  1  block can accept a pattern.
pattern_in  input  T_WINDOW  compressed pattern; bit 0 = newest spike, bit T_WINDOW-1 = oldest.
weight_in  input  W_WIDTH  weight associated with the pattern.
ev_valid  output  1  event valid.
ev_ready  input  1  downstream accepts event.
ev_time  output  TW  timestep of event; 0 = oldest = T_WINDOW-1-bit_index.
ev_weight  output  W_WIDTH  latched weight_in.
ev_last  output  1  final event of current pattern.
done_pulse  output  1  one-cycle pulse: pattern fully consumed (including all-zero pattern).

Behaviour:
- Reset: synchronous on the clk edge with rst_n=0. Reset values:
  - state=IDLE, in_ready=0 during reset and 1 from the first cycle after rst_n rises.
  - ev_valid=0, ev_time=0, ev_weight=0, ev_last=0, done_pulse=0.
  - Internal pattern register = 0.
- Reset mid-operation discards any pending pattern and events. No done_pulse is generated.
- States:
  - IDLE: in_ready=1, ev_valid=0.
  - EMIT: in_ready=0, ev_valid=1.
- Accept: occurs on a cycle where in_valid&&in_ready. Latch pattern_in into pat_r and weight_in into ev_weight.
  - If pattern_in != 0: go to EMIT. The first event is visible the next cycle (1-cycle latency).
  - If pattern_in == 0: stay IDLE, assert done_pulse the next cycle. in_ready stays 1, so back-to-back zero patterns are accepted every cycle.
- Event selection (EMIT): ev_time = T_WINDOW-1-(index of highest set bit of pat_r), computed combinationally by a priority encoder from the MSB. ev_last=1 when exactly one bit remains in pat_r.
- Handshake in EMIT:
  - ev_valid is held until ev_ready. ev_time, ev_weight and ev_last are stable while ev_valid&&!ev_ready.
  - On ev_valid&&ev_ready: clear the highest set bit of pat_r.
  - If that event had ev_last=1: go to IDLE and assert done_pulse the next cycle (same cycle in which in_ready returns to 1).
  - Otherwise the next event is presented the immediately following cycle.
- Throughput: a pattern with k>0 set bits occupies k+1 cycles from accept to the next accept, with ev_ready held high. Events are strictly ordered by increasing ev_time.
- Boundaries:
  - All-ones pattern produces T_WINDOW events with times 0..T_WINDOW-1; ev_last only on the final one.
  - A single-bit pattern gives one event with ev_last=1.
  - in_valid during EMIT is ignored (in_ready=0). Upstream must hold its data.
- done_pulse is never asserted in the same cycle as ev_valid.

Optional Feature:
Macro: TPPE_SCAN_STATS_EN.
- Defined: adds output stat_event_count [31:0], which counts every event handshake (ev_valid&&ev_ready). It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Also adds output stat_pattern_count [15:0], which counts accepted patterns (zero patterns included) and wraps at 16'hFFFF->0.
- Not defined: both ports and counters are absent. Core behaviour is identical in both builds.

Test Plan:
1. Pattern 16'h8001, weight 8'sd5, ev_ready=1.
   -> Events (time 0, w 5, last 0) then (time 15, w 5, last 1).
   -> done_pulse on the cycle after the 2nd handshake; in_ready high again that cycle.
2. Pattern 16'h0000 presented three consecutive cycles.
   -> No ev_valid.
   -> done_pulse high three consecutive cycles, each one cycle after its accept; in_ready never drops.
3. Pattern 16'hFFFF, weight -3, ev_ready=1.
   -> 16 events, times 0..15 on consecutive cycles, ev_weight=-3 on all, ev_last only on time 15.
   -> Accept-to-next-accept = 17 cycles.
4. Pattern 16'h0420, ev_ready toggled 1,0,0,1.
   -> Event time 5 accepted first.
   -> Event time 10 held stable, ev_last=1, through both stall cycles, then accepted.
   -> done_pulse follows that accept.
5. rst_n=0 for one cycle while emitting the 2nd of 4 events (pattern 16'hF000).
   -> Next cycle ev_valid=0, done_pulse=0.
   -> in_ready=1 the cycle after rst_n rises.
   -> A new pattern 16'h0001 yields a single event at time 15.
6. With TPPE_SCAN_STATS_EN: run scenarios 1 and 2.
   -> stat_event_count=2, stat_pattern_count=4.

Source files
------------

// File: rtl/tppe_spike_event_scanner_if.sv
// Handshake bundle between the spike compressor, the event scanner and the
// LIF accumulation stage. slave = scanner side, master = upstream/downstream side.
interface tppe_spike_event_scanner_if #(
  parameter int T_WINDOW = 16,
  parameter int W_WIDTH  = 8
);
  localparam int TW = $clog2(T_WINDOW);

  logic                in_valid;
  logic                in_ready;
  logic [T_WINDOW-1:0] pattern_in;
  logic [W_WIDTH-1:0]  weight_in;
  logic                ev_valid;
  logic                ev_ready;
  logic [TW-1:0]       ev_time;
  logic [W_WIDTH-1:0]  ev_weight;
  logic                ev_last;
  logic                done_pulse;

  modport slave (
    input  in_valid, pattern_in, weight_in, ev_ready,
    output in_ready, ev_valid, ev_time, ev_weight, ev_last, done_pulse
  );

  modport master (
    output in_valid, pattern_in, weight_in, ev_ready,
    input  in_ready, ev_valid, ev_time, ev_weight, ev_last, done_pulse
  );
endinterface

// File: rtl/tppe_spike_event_scanner.sv
// Spike event scanner: turns a dense T_WINDOW-bit spike pattern into a sparse
// stream of (timestep, weight) events, oldest spike (MSB) first.
// Optional build macro TPPE_SCAN_STATS_EN adds event/pattern statistics ports.
module tppe_spike_event_scanner #(
  parameter int T_WINDOW = 16,
  parameter int W_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst_n,
  tppe_spike_event_scanner_if.slave bus
`ifdef TPPE_SCAN_STATS_EN
  ,
  output logic [31:0] stat_event_count,
  output logic [15:0] stat_pattern_count
`endif
);
  localparam int TW = $clog2(T_WINDOW);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t              r_state;
  logic [T_WINDOW-1:0] r_pat;
  logic [W_WIDTH-1:0]  r_weight;
  logic                r_in_ready;
  logic                r_ev_valid;
  logic                r_done;

  logic [TW-1:0]       w_idx;
  logic [TW-1:0]       w_time;
  logic                w_last;
  logic [T_WINDOW-1:0] w_pat_clr;
  logic                w_accept;
  logic                w_ev_hs;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_ev_hs  = r_ev_valid & bus.ev_ready;

  // Priority encoder: the highest set bit is the oldest pending spike.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < T_WINDOW; i++)
      if (r_pat[i]) w_idx = TW'(i);
    w_time    = (r_pat == '0) ? '0 : (TW'(T_WINDOW - 1) - w_idx);
    w_last    = (r_pat != '0) && ((r_pat & (r_pat - 1'b1)) == '0);
    w_pat_clr = r_pat & ~({{(T_WINDOW-1){1'b0}}, 1'b1} << w_idx);
  end

  // Control FSM with registered handshake outputs; in_ready stays low through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pat      <= '0;
      r_weight   <= '0;
      r_in_ready <= 1'b0;
      r_ev_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          r_ev_valid <= 1'b0;
          if (w_accept) begin
            r_pat    <= bus.pattern_in;
            r_weight <= bus.weight_in;
            if (bus.pattern_in != '0) begin
              r_state    <= EMIT;
              r_in_ready <= 1'b0;
              r_ev_valid <= 1'b1;
            end else begin
              // Empty pattern: nothing to emit, report completion straight away.
              r_done <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (w_ev_hs) begin
            r_pat <= w_pat_clr;
            if (w_last) begin
              r_state    <= IDLE;
              r_ev_valid <= 1'b0;
              r_in_ready <= 1'b1;
              r_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ev_valid <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.ev_valid   = r_ev_valid;
  assign bus.ev_time    = w_time;
  assign bus.ev_weight  = r_weight;
  assign bus.ev_last    = w_last;
  assign bus.done_pulse = r_done;

`ifdef TPPE_SCAN_STATS_EN
  logic [31:0] r_ev_cnt;
  logic [15:0] r_pat_cnt;

  // Event count saturates; pattern count wraps. Both clear only on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ev_cnt  <= '0;
      r_pat_cnt <= '0;
    end else begin
      if (w_ev_hs && (r_ev_cnt != 32'hFFFF_FFFF)) r_ev_cnt <= r_ev_cnt + 32'd1;
      if (w_accept) r_pat_cnt <= r_pat_cnt + 16'd1;
    end
  end

  assign stat_event_count   = r_ev_cnt;
  assign stat_pattern_count = r_pat_cnt;
`endif
endmodule

// File: tb/tb_tppe_spike_event_scanner.sv
// Self-checking bench for tppe_spike_event_scanner: directed scenarios plus
// randomized patterns, compared against a list-of-set-bits reference model.
module tb_tppe_spike_event_scanner;
  localparam int T_WINDOW = 16;
  localparam int W_WIDTH  = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   exp_ev;
  int   exp_pat;
  bit   rdy_seq[$];

  tppe_spike_event_scanner_if #(.T_WINDOW(T_WINDOW), .W_WIDTH(W_WIDTH)) ifc ();

`ifdef TPPE_SCAN_STATS_EN
  logic [31:0] stat_event_count;
  logic [15:0] stat_pattern_count;
`endif

  tppe_spike_event_scanner #(.T_WINDOW(T_WINDOW), .W_WIDTH(W_WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
`ifdef TPPE_SCAN_STATS_EN
    ,
    .stat_event_count   (stat_event_count),
    .stat_pattern_count (stat_pattern_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one pattern at the current negedge and follow it to completion.
  // Expected events: timestep t for every set bit at position T_WINDOW-1-t, ascending t.
  task automatic send(input logic [15:0] pat, input logic [7:0] w, input bit rnd_rdy);
    int q[$];
    int cyc;
    int stalls;
    int k;
    int to;
    bit r;
    for (int t = 0; t < T_WINDOW; t++)
      if (pat[T_WINDOW-1-t]) q.push_back(t);
    k = q.size();
    to = 0;
    while (!ifc.in_ready && to < 50) begin
      @(negedge clk);
      to++;
    end
    chk("in_ready_pre", {31'b0, ifc.in_ready}, 32'd1);
    ifc.in_valid   = 1'b1;
    ifc.pattern_in = pat;
    ifc.weight_in  = w;
    exp_pat++;
    cyc = 0;
    stalls = 0;
    @(negedge clk);
    cyc++;
    ifc.in_valid   = 1'b0;
    ifc.pattern_in = 16'($urandom);
    while (q.size() > 0 && cyc < 200) begin
      chk("ev_valid", {31'b0, ifc.ev_valid}, 32'd1);
      chk("in_ready_emit", {31'b0, ifc.in_ready}, 32'd0);
      chk("done_emit", {31'b0, ifc.done_pulse}, 32'd0);
      chk("ev_time", {28'b0, ifc.ev_time}, q[0]);
      chk("ev_weight", {24'b0, ifc.ev_weight}, {24'b0, w});
      chk("ev_last", {31'b0, ifc.ev_last}, (q.size() == 1) ? 32'd1 : 32'd0);
      if (rdy_seq.size() > 0) r = rdy_seq.pop_front();
      else r = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
      ifc.ev_ready = r;
      // Junk upstream traffic while busy must be ignored.
      ifc.in_valid   = 1'($urandom);
      ifc.pattern_in = 16'($urandom);
      @(negedge clk);
      cyc++;
      if (r) begin
        void'(q.pop_front());
        exp_ev++;
      end else begin
        stalls++;
      end
    end
    chk("drain_timeout", q.size(), 0);
    ifc.in_valid = 1'b0;
    ifc.ev_ready = 1'($urandom);
    chk("done_pulse", {31'b0, ifc.done_pulse}, 32'd1);
    chk("ev_valid_done", {31'b0, ifc.ev_valid}, 32'd0);
    chk("in_ready_done", {31'b0, ifc.in_ready}, 32'd1);
    chk("occupancy", cyc - stalls, k + 1);
  endtask

  initial begin
    logic [15:0] p;
    n_chk = 0; n_fail = 0; exp_ev = 0; exp_pat = 0;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.pattern_in = '0; ifc.weight_in = '0; ifc.ev_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, ifc.in_ready}, 32'd0);
    chk("rst_ev_valid", {31'b0, ifc.ev_valid}, 32'd0);
    chk("rst_ev_time", {28'b0, ifc.ev_time}, 32'd0);
    chk("rst_ev_weight", {24'b0, ifc.ev_weight}, 32'd0);
    chk("rst_ev_last", {31'b0, ifc.ev_last}, 32'd0);
    chk("rst_done", {31'b0, ifc.done_pulse}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);

    // Scenario 1 and 2: two-event pattern, then three back-to-back empty patterns.
    send(16'h8001, 8'd5, 1'b0);
    repeat (3) send(16'h0000, 8'h11, 1'b0);
`ifdef TPPE_SCAN_STATS_EN
    chk("stat_event_count", stat_event_count, 32'd2);
    chk("stat_pattern_count", {16'b0, stat_pattern_count}, 32'd4);
`endif

    // Scenario 3: all ones, negative weight.
    send(16'hFFFF, 8'hFD, 1'b0);

    // Scenario 4: stall on the last event.
    rdy_seq.push_back(1'b1); rdy_seq.push_back(1'b0);
    rdy_seq.push_back(1'b0); rdy_seq.push_back(1'b1);
    send(16'h0420, 8'h7F, 1'b0);

    // Scenario 5: reset while the 2nd of 4 events is showing.
    ifc.in_valid = 1'b1; ifc.pattern_in = 16'hF000; ifc.weight_in = 8'h22; ifc.ev_ready = 1'b1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("r5_ev0_time", {28'b0, ifc.ev_time}, 32'd0);
    @(negedge clk);
    chk("r5_ev1_time", {28'b0, ifc.ev_time}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r5_ev_valid", {31'b0, ifc.ev_valid}, 32'd0);
    chk("r5_done", {31'b0, ifc.done_pulse}, 32'd0);
    chk("r5_in_ready_rst", {31'b0, ifc.in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r5_in_ready", {31'b0, ifc.in_ready}, 32'd1);
    chk("r5_done_after", {31'b0, ifc.done_pulse}, 32'd0);
    send(16'h0001, 8'h80, 1'b0);

    // Randomized patterns: mix of dense, empty and single-bit, with random stalls.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(3))
        0: p = 16'h0000;
        1: p = 16'h0001 << $urandom_range(15);
        default: p = 16'($urandom);
      endcase
      send(p, 8'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
